// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  // Requester side: issues operands, observes status and results.
  modport master (
    output start_in, a_in, b_in,
    input  busy, done, diff, borrow, overflow
  );

  // Subtractor side.
  modport slave (
    input  start_in, a_in, b_in,
    output busy, done, diff, borrow, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell processes the operands LSB first,
// one bit per clock, and publishes diff/borrow/overflow only on completion.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic             bin_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             overflow_q;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             bout;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs and the incoming borrow.
  always_comb begin
    a_bit    = a_sh_q[0];
    b_bit    = b_sh_q[0];
    d_bit    = a_bit ^ b_bit ^ bin_q;
    bout     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
    // New difference bit enters at the MSB end of the result register.
    res_next = WIDTH'({d_bit, res_q} >> 1);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // FSM plus datapath state; outputs only move on the SUB-to-DONE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_q      <= '0;
      bin_q      <= 1'b0;
      cnt_q      <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_in) begin
            a_sh_q  <= bus.a_in;
            b_sh_q  <= bus.b_in;
            bin_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StSub;
          end
        end
        StSub: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          res_q  <= res_next;
          bin_q  <= bout;
          if (last_bit) begin
            // On the final bit the shifted-down LSBs are the original operand MSBs
            // and d_bit is the result MSB.
            diff_q     <= res_next;
            borrow_q   <= bout;
            overflow_q <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Status flags are plain decodes of the registered state.
  always_comb begin
    bus.busy     = (state_q == StSub);
    bus.done     = (state_q == StDone);
    bus.diff     = diff_q;
    bus.borrow   = borrow_q;
    bus.overflow = overflow_q;
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results computed
// with plain arithmetic; a monitor pops and compares whenever done is seen.
module tb_serial_subtractor;
  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           cy;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;
  int   last_acc;
  int   next_accept;
  exp_t sb_q[$];
  logic [W-1:0] held_d;
  logic         held_bo;
  logic         held_ov;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: modular difference, unsigned compare, signed range test.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int cy);
    exp_t e;
    int   sa;
    int   sb;
    int   r;
    sa   = (int'(a) >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
    sb   = (int'(b) >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
    r    = sa - sb;
    e.d  = W'(int'(a) - int'(b));
    e.bo = (a < b);
    e.ov = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    e.cy = cy;
    return e;
  endfunction

  // Called just after a falling edge; the start covers exactly the next rising edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in     = a;
    bus.b_in     = b;
    bus.start_in = 1'b1;
    if (cyc + 1 >= next_accept) begin
      sb_q.push_back(model(a, b, cyc + 1 + W));
      last_acc    = cyc + 1;
      next_accept = cyc + 1 + W + 2;
    end
    @(negedge clk);
    bus.start_in = 1'b0;
    bus.a_in     = W'($urandom);
    bus.b_in     = W'($urandom);
  endtask

  task automatic wait_ready();
    while (cyc + 1 < next_accept) @(negedge clk);
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        chk("busy", 32'(bus.busy), 32'((cyc >= last_acc) && (cyc < last_acc + W)));
        if (bus.done) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'(bus.done), 32'd0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.cy));
            held_d  = e.d;
            held_bo = e.bo;
            held_ov = e.ov;
          end
        end else if (sb_q.size() > 0 && sb_q[0].cy < cyc) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("missing_done", 32'(cyc), 32'(e.cy));
          held_d  = e.d;
          held_bo = e.bo;
          held_ov = e.ov;
        end
        chk("diff", 32'(bus.diff), 32'(held_d));
        chk("borrow", 32'(bus.borrow), 32'(held_bo));
        chk("overflow", 32'(bus.overflow), 32'(held_ov));
      end
    end
  end

  initial begin
    int budget;
    cyc          = 0;
    tests        = 0;
    fails        = 0;
    last_acc     = -1000;
    next_accept  = 0;
    held_d       = '0;
    held_bo      = 1'b0;
    held_ov      = 1'b0;
    bus.start_in = 1'b0;
    bus.a_in     = '0;
    bus.b_in     = '0;
    rst          = 1'b1;
    #3;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_borrow", 32'(bus.borrow), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    next_accept = cyc + 1;

    // Directed cases.
    issue(8'h5A, 8'h3C); wait_ready();
    issue(8'h00, 8'h01); wait_ready();
    issue(8'h80, 8'h01); wait_ready();
    issue(8'h7F, 8'hFF); wait_ready();

    // Start pulse during SUB cycle 3 with different operands must be ignored.
    issue(8'h12, 8'h34);
    while (cyc < last_acc + 2) @(negedge clk);
    issue(8'hFF, 8'h00);
    wait_ready();

    // Reset during SUB cycle 4 aborts with no done pulse.
    issue(8'hC3, 8'h21);
    while (cyc < last_acc + 3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_borrow", 32'(bus.borrow), 32'd0);
    chk("abort_overflow", 32'(bus.overflow), 32'd0);
    sb_q.delete();
    held_d   = '0;
    held_bo  = 1'b0;
    held_ov  = 1'b0;
    last_acc = -1000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    next_accept = cyc + 1;
    issue(8'h10, 8'h10); wait_ready();

    // Back-to-back at the earliest legal edge.
    issue(8'h01, 8'h02); wait_ready();
    issue(8'hA0, 8'h50); wait_ready();
    issue(8'h00, 8'h00); wait_ready();

    // Random operands and randomly timed start pulses, many landing while busy.
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) issue(W'($urandom), W'($urandom));
      else @(negedge clk);
    end

    budget = 0;
    while (sb_q.size() > 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
